// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the single-clock programmable FIFO.
// Sizes are derived from ADDRSIZE at elaboration time.
package sync_fifo_pkg;

    localparam int DEF_DATASIZE = 8;
    localparam int DEF_ADDRSIZE = 8;

    // Pointers carry one extra wrap bit above the memory address.
    function automatic int ptr_width(input int addrsize);
        return addrsize + 1;
    endfunction

    // Occupancy at which the half-full flag asserts.
    function automatic int half_level(input int addrsize);
        return (1 << addrsize) / 2;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DATASIZE x DEPTH storage with one synchronous write port and one read port.
// SYNC_FIFO_FWFT_EN makes the read port combinational; otherwise it is registered.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic                clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic                rst,
    input  logic                re,
`endif
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem_q [DEPTH];

    // Write port: store the word on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is always visible; the consumer pops it with the read strobe.
    assign rdata = mem_q[raddr];
`else
    logic [DATASIZE-1:0] rdata_q;

    // Read port: capture the head word on an accepted read, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, occupancy count and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATASIZE = DEF_DATASIZE,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_inc,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                r_inc,
    output logic [DATASIZE-1:0] rdata,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic [ADDRSIZE:0]   aempty_thresh,
    input  logic                clr_err,
    output logic                wfull,
    output logic                hfull,
    output logic                rempty,
    output logic                hempty,
    output logic                afull,
    output logic                aempty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int PW    = ptr_width(ADDRSIZE);
    localparam int DEPTH = 1 << ADDRSIZE;
    localparam int HALF  = half_level(ADDRSIZE);

    localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
    localparam logic [PW-1:0] HALF_V  = PW'(HALF);
    localparam logic [PW-1:0] ONE     = PW'(1);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          wfull_q, wfull_d;
    logic          hfull_q, hfull_d;
    logic          rempty_q, rempty_d;
    logic          hempty_q, hempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          w_acc;
    logic          r_acc;

    // Accept decisions use the registered flags only.
    always_comb begin
        w_acc = w_inc && !wfull_q;
        r_acc = r_inc && !rempty_q;
    end

    // Next pointers, occupancy and the flags derived from the new occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_acc) begin
            wptr_d = wptr_q + ONE;
        end
        if (r_acc) begin
            rptr_d = rptr_q + ONE;
        end
        if (w_acc && !r_acc) begin
            count_d = count_q + ONE;
        end else if (!w_acc && r_acc) begin
            count_d = count_q - ONE;
        end
        wfull_d  = (count_d == DEPTH_V);
        hfull_d  = (count_d >= HALF_V);
        rempty_d = (count_d == '0);
        hempty_d = (count_d < HALF_V);
    end

    // Sticky errors: a new error event outranks a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (w_inc && wfull_q) begin
            ovf_d = 1'b1;
        end
        if (r_inc && rempty_q) begin
            udf_d = 1'b1;
        end
    end

    // State registers for pointers, occupancy, level flags and errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            hfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            hempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            wfull_q  <= wfull_d;
            hfull_q  <= hfull_d;
            rempty_q <= rempty_d;
            hempty_q <= hempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sync_fifo_mem #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .rst   (rst),
        .re    (r_acc),
`endif
        .we    (w_acc),
        .waddr (wptr_q[ADDRSIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr_q[ADDRSIZE-1:0]),
        .rdata (rdata)
    );

    // Thresholds are live inputs, so compare them against the registered
    // count directly: a new threshold takes effect immediately and the
    // flags still track count every cycle, including during reset.
    always_comb begin
        afull  = (count_q >= afull_thresh);
        aempty = (count_q <= aempty_thresh);
    end

    assign wfull     = wfull_q;
    assign hfull     = hfull_q;
    assign rempty    = rempty_q;
    assign hempty    = hempty_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
